// File: rtl/stopwatch_datapath.sv
// stopwatch_datapath
//   Cascaded elapsed-time counter driven by the 100 Hz tick pulse. Keeps
//   centiseconds, seconds, minutes and hours, a lap-capture snapshot and
//   a one-cycle pulse when the whole time wraps back to zero.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   i_tick          one-cycle count enable (one centisecond)
//   clear           level; zeroes time, lap state and rollover
//   lap             one-cycle pulse; snapshots the pre-tick time
//   o_msec..o_hour  live time fields
//   o_lap_*         captured lap time
//   o_lap_valid     a lap has been captured since the last rst/clear
//   o_rollover      pulses in the cycle the zeroed time first appears
module stopwatch_datapath #(
  parameter int MSEC_MAX = 100,
  parameter int SEC_MAX  = 60,
  parameter int MIN_MAX  = 60,
  parameter int HOUR_MAX = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_tick,
  input  logic                        clear,
  input  logic                        lap,
  output logic [$clog2(MSEC_MAX)-1:0] o_msec,
  output logic [$clog2(SEC_MAX)-1:0]  o_sec,
  output logic [$clog2(MIN_MAX)-1:0]  o_min,
  output logic [$clog2(HOUR_MAX)-1:0] o_hour,
  output logic [$clog2(MSEC_MAX)-1:0] o_lap_msec,
  output logic [$clog2(SEC_MAX)-1:0]  o_lap_sec,
  output logic [$clog2(MIN_MAX)-1:0]  o_lap_min,
  output logic [$clog2(HOUR_MAX)-1:0] o_lap_hour,
  output logic                        o_lap_valid,
  output logic                        o_rollover
);

  localparam int MW = $clog2(MSEC_MAX);
  localparam int SW = $clog2(SEC_MAX);
  localparam int NW = $clog2(MIN_MAX);
  localparam int HW = $clog2(HOUR_MAX);

  localparam logic [MW-1:0] MSEC_TOP = MW'(MSEC_MAX - 1);
  localparam logic [SW-1:0] SEC_TOP  = SW'(SEC_MAX - 1);
  localparam logic [NW-1:0] MIN_TOP  = NW'(MIN_MAX - 1);
  localparam logic [HW-1:0] HOUR_TOP = HW'(HOUR_MAX - 1);

  // Carry chain resolved combinationally so a multi-field carry lands in
  // one edge; each stage only advances when everything below it wraps.
  logic c_sec, c_min, c_hour, wrap;

  always_comb begin
    c_sec  = i_tick && (o_msec == MSEC_TOP);
    c_min  = c_sec  && (o_sec  == SEC_TOP);
    c_hour = c_min  && (o_min  == MIN_TOP);
    wrap   = c_hour && (o_hour == HOUR_TOP);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      o_msec      <= '0;
      o_sec       <= '0;
      o_min       <= '0;
      o_hour      <= '0;
      o_lap_msec  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_hour  <= '0;
      o_lap_valid <= 1'b0;
      o_rollover  <= 1'b0;
    end else begin
      o_rollover <= wrap;
      if (i_tick) o_msec <= c_sec  ? '0 : o_msec + 1'b1;
      if (c_sec)  o_sec  <= c_min  ? '0 : o_sec  + 1'b1;
      if (c_min)  o_min  <= c_hour ? '0 : o_min  + 1'b1;
      if (c_hour) o_hour <= wrap   ? '0 : o_hour + 1'b1;
      // Snapshot uses the register values, i.e. time before a same-cycle tick.
      if (lap) begin
        o_lap_msec  <= o_msec;
        o_lap_sec   <= o_sec;
        o_lap_min   <= o_min;
        o_lap_hour  <= o_hour;
        o_lap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Bench for stopwatch_datapath: a default-size instance and a shrunken
// instance (4/3/3/2) share stimulus so full rollover and the last-minute
// carry are reachable in a few dozen ticks. A reference model holds time
// as a single centisecond count and derives fields by division.
module tb_stopwatch_datapath;

  localparam int BM = 100, BS = 60, BN = 60, BH = 24;
  localparam int SM = 4,   SS = 3,  SN = 3,  SH = 2;
  localparam int BP = BM * BS * BN * BH;
  localparam int SP = SM * SS * SN * SH;

  logic clk = 1'b0;
  logic rst = 1'b0, i_tick = 1'b0, clear = 1'b0, lap = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] b_msec, b_lmsec;
  logic [5:0] b_sec, b_lsec, b_min, b_lmin;
  logic [4:0] b_hour, b_lhour;
  logic       b_lv, b_ro;
  logic [1:0] s_msec, s_lmsec, s_sec, s_lsec, s_min, s_lmin;
  logic [0:0] s_hour, s_lhour;
  logic       s_lv, s_ro;

  stopwatch_datapath u_big (
    .clk(clk), .rst(rst), .i_tick(i_tick), .clear(clear), .lap(lap),
    .o_msec(b_msec), .o_sec(b_sec), .o_min(b_min), .o_hour(b_hour),
    .o_lap_msec(b_lmsec), .o_lap_sec(b_lsec), .o_lap_min(b_lmin),
    .o_lap_hour(b_lhour), .o_lap_valid(b_lv), .o_rollover(b_ro));

  stopwatch_datapath #(.MSEC_MAX(SM), .SEC_MAX(SS), .MIN_MAX(SN), .HOUR_MAX(SH)) u_small (
    .clk(clk), .rst(rst), .i_tick(i_tick), .clear(clear), .lap(lap),
    .o_msec(s_msec), .o_sec(s_sec), .o_min(s_min), .o_hour(s_hour),
    .o_lap_msec(s_lmsec), .o_lap_sec(s_lsec), .o_lap_min(s_lmin),
    .o_lap_hour(s_lhour), .o_lap_valid(s_lv), .o_rollover(s_ro));

  typedef struct packed {
    logic [7:0] msec, sec, min, hour, lmsec, lsec, lmin, lhour;
    logic       lv, ro;
  } obs_t;

  typedef struct {
    int t;   // elapsed centiseconds modulo the full period
    int lt;  // captured lap, same units
    bit lv;
    bit ro;
  } mdl_t;

  mdl_t mb, ms;
  obs_t qb[$], qs[$];
  int n_checks = 0, n_pass = 0;

  function automatic obs_t to_obs(mdl_t m, int M, int S, int N);
    obs_t o;
    o.msec  = 8'(m.t % M);
    o.sec   = 8'((m.t / M) % S);
    o.min   = 8'((m.t / (M * S)) % N);
    o.hour  = 8'(m.t / (M * S * N));
    o.lmsec = 8'(m.lt % M);
    o.lsec  = 8'((m.lt / M) % S);
    o.lmin  = 8'((m.lt / (M * S)) % N);
    o.lhour = 8'(m.lt / (M * S * N));
    o.lv    = m.lv;
    o.ro    = m.ro;
    return o;
  endfunction

  function automatic mdl_t adv(mdl_t m, bit r, bit c, bit tk, bit lp, int P);
    mdl_t n = m;
    if (r || c) begin
      n.t = 0; n.lt = 0; n.lv = 1'b0; n.ro = 1'b0;
      return n;
    end
    n.ro = tk && (m.t == P - 1);
    if (lp) begin n.lt = m.t; n.lv = 1'b1; end
    if (tk) n.t = (m.t + 1) % P;
    return n;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_obs(string nm, obs_t got, obs_t exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state,
  // and return shortly after the edge so directed checks can look.
  task automatic step(bit r, bit c, bit tk, bit lp);
    @(negedge clk);
    rst = r; clear = c; i_tick = tk; lap = lp;
    mb = adv(mb, r, c, tk, lp, BP);
    ms = adv(ms, r, c, tk, lp, SP);
    qb.push_back(to_obs(mb, BM, BS, BN));
    qs.push_back(to_obs(ms, SM, SS, SN));
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        g = '{8'(b_msec), 8'(b_sec), 8'(b_min), 8'(b_hour),
              8'(b_lmsec), 8'(b_lsec), 8'(b_lmin), 8'(b_lhour), b_lv, b_ro};
        chk_obs("big", g, e);
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        g = '{8'(s_msec), 8'(s_sec), 8'(s_min), 8'(s_hour),
              8'(s_lmsec), 8'(s_lsec), 8'(s_lmin), 8'(s_lhour), s_lv, s_ro};
        chk_obs("small", g, e);
      end
    end
  end

  initial begin
    mb = '{0, 0, 1'b0, 1'b0};
    ms = '{0, 0, 1'b0, 1'b0};

    // Reset with random tick/lap noise, then one tick.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    chk("rst_msec", b_msec, 0);
    chk("rst_lv", b_lv, 0);
    ticks(1);
    chk("first_tick_msec", b_msec, 1);

    // Carries at default size.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(100);
    chk("c100_msec", b_msec, 0);
    chk("c100_sec", b_sec, 1);
    ticks(5900);
    chk("c6000_min", b_min, 1);
    chk("c6000_sec", b_sec, 0);
    chk("c6000_msec", b_msec, 0);

    // Full rollover on the small instance (period 72).
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SP - 1);
    chk("pre_wrap_ro", s_ro, 0);
    chk("pre_wrap_hour", s_hour, SH - 1);
    chk("pre_wrap_msec", s_msec, SM - 1);
    ticks(1);
    chk("wrap_ro", s_ro, 1);
    chk("wrap_hour", s_hour, 0);
    chk("wrap_min", s_min, 0);
    ticks(1);
    chk("post_wrap_ro", s_ro, 0);
    chk("post_wrap_msec", s_msec, 1);

    // Clear beats a same-cycle tick; held clear drops ticks.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(200);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(336);
    chk("at537_sec", b_sec, 5);
    chk("at537_msec", b_msec, 37);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_msec", b_msec, 0);
    chk("clr_sec", b_sec, 0);
    chk("clr_lv", b_lv, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_hold_msec", b_msec, 0);
    ticks(1);
    chk("clr_release_msec", b_msec, 1);

    // Lap together with a carrying tick, then an overwrite.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(399);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("lap_msec", b_lmsec, 99);
    chk("lap_sec", b_lsec, 3);
    chk("live_msec", b_msec, 0);
    chk("live_sec", b_sec, 4);
    chk("lap_lv", b_lv, 1);
    ticks(50);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap2_msec", b_lmsec, 50);
    chk("lap2_sec", b_lsec, 4);
    chk("lap2_lv", b_lv, 1);

    // Reset during the last-hour carry on the small instance.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SP / SH - 1);
    chk("mid_min", s_min, SN - 1);
    chk("mid_hour", s_hour, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_hour", s_hour, 0);
    chk("mid_rst_min", s_min, 0);
    chk("mid_rst_msec", s_msec, 0);
    chk("mid_rst_ro", s_ro, 0);

    // Random soak.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && (qb.size() > 0 || qs.size() > 0); i++) @(posedge clk);
    #3;
    chk("queue_drain", qb.size() + qs.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
